// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the main-decoder slice.
//   - opcode constants for the recognised instructions
//   - ALU operation class enum
//   - packed control word produced by control_decoder
// Optional feature macro: CU_JUMP_EN adds the jump field to the control word.
package control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    branch;
        logic    mem_write;
        logic    mem_to_reg;
        alu_op_e alu_op;
        logic    illegal;
`ifdef CU_JUMP_EN
        logic    jump;
`endif
    } ctrl_word_t;

endpackage

// File: rtl/control_decoder.sv
// control_decoder: purely combinational opcode -> control word decode.
// Ports:
//   opcode  in   OPCODE_W  instruction bits [31:26]
//   ctrl    out  control word (see control_unit_pkg::ctrl_word_t)
// Optional feature macro: CU_JUMP_EN decodes opcode 000010 as a jump.
module control_decoder
    import control_unit_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          ctrl
);

    always_comb begin
        // Anything not matched below is an illegal opcode with every
        // control deasserted, so no register or memory write can happen.
        ctrl         = '0;
        ctrl.alu_op  = ALU_ADD;
        ctrl.illegal = 1'b1;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OPCODE_W'(OP_LW): begin
                ctrl.illegal    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            // RegDst / MemtoReg are don't-cares for sw and beq; held at 0.
            OPCODE_W'(OP_SW): begin
                ctrl.illegal   = 1'b0;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                ctrl.illegal = 1'b0;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_SUB;
            end
            OPCODE_W'(OP_ADDI): begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
`ifdef CU_JUMP_EN
            OPCODE_W'(OP_J): begin
                ctrl.illegal = 1'b0;
                ctrl.jump    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: registered main decoder. The opcode seen at a rising edge is
// decoded by control_decoder and its control word appears after that edge.
// Ports:
//   clk       in   clock (rising edge)
//   rst       in   synchronous active-high reset, clears every output
//   opcode    in   OPCODE_W instruction bits [31:26]
//   MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite  out  1-bit controls
//   ALUOp     out  ALUOP_W ALU class (00 add, 01 sub, 10 funct)
//   illegal   out  opcode not recognised
//   Jump      out  unconditional jump (only when CU_JUMP_EN is defined)
// Optional feature macro: CU_JUMP_EN.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                MemtoReg,
    output logic                MemWrite,
    output logic                Branch,
    output logic                ALUSrc,
    output logic                RegDst,
    output logic                RegWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                illegal
`ifdef CU_JUMP_EN
    ,
    output logic                Jump
`endif
);

    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;

    control_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    // Decode -> output register boundary; reset wins over the opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegWrite = ctrl_q.reg_write;
    assign RegDst   = ctrl_q.reg_dst;
    assign ALUSrc   = ctrl_q.alu_src;
    assign Branch   = ctrl_q.branch;
    assign MemWrite = ctrl_q.mem_write;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign ALUOp    = ALUOP_W'(ctrl_q.alu_op);
    assign illegal  = ctrl_q.illegal;
`ifdef CU_JUMP_EN
    assign Jump     = ctrl_q.jump;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios, a full opcode
// sweep and random opcodes/resets compared against a table-driven model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, illegal;
    logic [1:0] ALUOp;
    logic       jump_obs;

    int total = 0;
    int bad   = 0;

`ifdef CU_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
    logic Jump;
    assign jump_obs = Jump;
`else
    localparam bit JUMP_EN = 1'b0;
    assign jump_obs = 1'b0;
`endif

    control_unit #(.OPCODE_W(6), .ALUOP_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .ALUOp    (ALUOp),
        .illegal  (illegal)
`ifdef CU_JUMP_EN
        ,
        .Jump     (Jump)
`endif
    );

    always #5 clk = ~clk;

    // Observed row: RegWrite RegDst ALUSrc Branch MemWrite MemtoReg ALUOp illegal Jump
    logic [9:0] obs;
    assign obs = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg,
                  ALUOp, illegal, jump_obs};

    // Reference: the instruction table as a 64-entry lookup.
    logic [9:0] ref_tab [64];

    initial begin
        for (int i = 0; i < 64; i++) ref_tab[i] = 10'b000000_00_1_0;
        ref_tab[6'b000000] = 10'b110000_10_0_0;
        ref_tab[6'b100011] = 10'b101001_00_0_0;
        ref_tab[6'b101011] = 10'b001010_00_0_0;
        ref_tab[6'b000100] = 10'b000100_01_0_0;
        ref_tab[6'b001000] = 10'b101000_00_0_0;
        if (JUMP_EN) ref_tab[6'b000010] = 10'b000000_00_0_1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply opcode/rst, clock one edge, compare outputs and invariants.
    task automatic step(input logic [5:0] op, input logic r, input string tag);
        logic [9:0] exp;
        opcode = op;
        rst    = r;
        @(posedge clk);
        #1;
        exp = r ? 10'b0 : ref_tab[op];
        check(tag, {22'b0, obs}, {22'b0, exp});
        check({tag, "_aluop11"}, {31'b0, ALUOp == 2'b11}, 32'd0);
        check({tag, "_mw_rw"}, {31'b0, MemWrite & RegWrite}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'b100011;
        #2;
        step(6'b100011, 1'b1, "rst0");
        step(6'b100011, 1'b1, "rst1");
        check("rst_illegal", {31'b0, illegal}, 32'd0);

        step(6'b000000, 1'b0, "rtype");
        step(6'b100011, 1'b0, "lw");
        step(6'b101011, 1'b0, "sw");
        step(6'b000100, 1'b0, "beq");
        step(6'b001000, 1'b0, "addi");

        step(6'b111111, 1'b0, "ill3f");
        check("ill3f_flag", {31'b0, illegal}, 32'd1);
        step(6'b000000, 1'b0, "rtype2");
        check("rtype2_aluop", {30'b0, ALUOp}, 32'd2);

        step(6'b100011, 1'b0, "lw_hold");
        step(6'b100011, 1'b1, "lw_rst");
        step(6'b100011, 1'b0, "lw_after");

        step(6'b000010, 1'b0, "jop");
        check("jop_illegal", {31'b0, illegal}, JUMP_EN ? 32'd0 : 32'd1);

        for (int i = 0; i < 64; i++) step(6'(i), 1'b0, "sweep");

        for (int i = 0; i < 200; i++)
            step(6'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
